// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared USB definitions for the token/handshake receive and transmit paths:
//   - the 4-bit PID codes (PRE and ERR share a code)
//   - pid_class(): token / handshake / data / invalid classification
//   - CRC5 polynomial, initial value and a single-bit step function
//   - receiver state enum
// -----------------------------------------------------------------------------
package usb_pkg;

    // Token PIDs
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    // Handshake PIDs
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;
    // Data PIDs
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    // Special / reserved PIDs, not accepted by this receiver
    localparam logic [3:0] PID_PRE   = 4'b1100;
    localparam logic [3:0] PID_ERR   = 4'b1100;
    localparam logic [3:0] PID_SPLIT = 4'b1000;
    localparam logic [3:0] PID_PING  = 4'b0100;
    localparam logic [3:0] PID_RSVD  = 4'b0000;

    // CRC5: x^5 + x^2 + 1
    localparam logic [4:0] CRC5_POLY = 5'b00101;
    localparam logic [4:0] CRC5_INIT = 5'b11111;

    typedef enum logic [1:0] {
        PID_CLS_INVALID,
        PID_CLS_TOKEN,
        PID_CLS_HANDSHAKE,
        PID_CLS_DATA
    } pid_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOK1,
        ST_TOK2,
        ST_DISCARD,
        ST_OUT
    } rx_state_e;

    function automatic pid_class_e pid_class(input logic [3:0] pid);
        pid_class_e cls;
        case (pid)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP:       cls = PID_CLS_TOKEN;
            PID_ACK, PID_NAK, PID_STALL, PID_NYET:     cls = PID_CLS_HANDSHAKE;
            PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: cls = PID_CLS_DATA;
            default:                                   cls = PID_CLS_INVALID;
        endcase
        return cls;
    endfunction

    // One serial CRC5 step; the bit enters the register MSB side.
    function automatic logic [4:0] crc5_step(input logic [4:0] r, input logic b);
        logic fb;
        fb = b ^ r[4];
        return {r[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    endfunction

endpackage

// File: rtl/crc5_calc.sv
// -----------------------------------------------------------------------------
// crc5_calc
// Combinational CRC5 over an 11-bit token field (7-bit address + 4-bit
// endpoint), starting from CRC5_INIT. Returns the raw register; the value sent
// on the wire is its complement.
//   din [10:0] : field bits, din[0] is the first bit on the wire
//   crc [4:0]  : CRC5 register after all 11 bits
// -----------------------------------------------------------------------------
module crc5_calc
    import usb_pkg::*;
(
    input  logic [10:0] din,
    output logic [4:0]  crc
);

    logic [4:0] acc;

    always_comb begin
        acc = CRC5_INIT;
        for (int i = 0; i < 11; i++) begin
            acc = crc5_step(acc, din[i]);
        end
        crc = acc;
    end

endmodule

// File: rtl/crc5_r.sv
// -----------------------------------------------------------------------------
// crc5_r
// USB token/handshake packet receiver. Takes the byte stream from the receive
// control block, validates the PID, reports every valid PID to link control,
// recovers addr/endp of token packets, checks their CRC5 and presents the
// token to the link layer with a valid/ready handshake.
//   clk, rst              : clock, synchronous active-high reset
//   rx_from_*             : input byte stream (sop/eop/valid/ready/data)
//   rx_con_pid_en/pid     : one-cycle PID report to link control
//   rx_pid/addr/endp      : received token fields
//   rx_valid / rx_ready   : token handshake to the link layer
//   rx_err                : one-cycle pulse on PID, CRC or length error
// -----------------------------------------------------------------------------
module crc5_r
    import usb_pkg::*;
#(
    parameter bit CHK_PID_CMP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_from_sop,
    input  logic       rx_from_eop,
    input  logic       rx_from_valid,
    output logic       rx_from_ready,
    input  logic [7:0] rx_from_data,
    output logic       rx_con_pid_en,
    output logic [3:0] rx_con_pid,
    output logic [3:0] rx_pid,
    output logic [6:0] rx_addr,
    output logic [3:0] rx_endp,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err
);

    rx_state_e  state_q, state_d;
    logic [3:0] tok_pid_q, tok_pid_d;
    logic [7:0] byte1_q, byte1_d;
    logic [3:0] rx_pid_q, rx_pid_d;
    logic [6:0] rx_addr_q, rx_addr_d;
    logic [3:0] rx_endp_q, rx_endp_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_err_q, rx_err_d;
    logic       con_pid_en_q, con_pid_en_d;
    logic [3:0] con_pid_q, con_pid_d;

    logic       xfer;
    logic       start_pkt;
    logic [3:0] pid_in;
    logic       cmp_ok;
    pid_class_e cls;
    logic [4:0] crc_reg;
    logic [4:0] crc_rx;
    logic       crc_ok;

    assign rx_from_ready = (state_q != ST_OUT);
    assign xfer          = rx_from_valid & rx_from_ready;

    // A sop byte starts a new packet both from IDLE and from DISCARD.
    assign start_pkt = xfer & rx_from_sop &
                       ((state_q == ST_IDLE) || (state_q == ST_DISCARD));

    assign pid_in = rx_from_data[3:0];
    assign cmp_ok = !CHK_PID_CMP || (rx_from_data[7:4] == ~rx_from_data[3:0]);
    assign cls    = pid_class(pid_in);

    // Byte1 is held so the whole 11-bit field is hashed in the byte2 cycle.
    crc5_calc u_crc5_calc (
        .din ({rx_from_data[2:0], byte1_q}),
        .crc (crc_reg)
    );

    // First CRC bit on the wire (data[3]) is the CRC MSB.
    assign crc_rx = {rx_from_data[3], rx_from_data[4], rx_from_data[5],
                     rx_from_data[6], rx_from_data[7]};
    assign crc_ok = (crc_rx == ~crc_reg);

    always_comb begin
        state_d      = state_q;
        tok_pid_d    = tok_pid_q;
        byte1_d      = byte1_q;
        rx_pid_d     = rx_pid_q;
        rx_addr_d    = rx_addr_q;
        rx_endp_d    = rx_endp_q;
        rx_valid_d   = rx_valid_q;
        rx_err_d     = 1'b0;
        con_pid_en_d = 1'b0;
        con_pid_d    = con_pid_q;

        case (state_q)
            ST_TOK1: begin
                if (xfer) begin
                    byte1_d = rx_from_data;
                    if (rx_from_eop) begin
                        rx_err_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_TOK2;
                    end
                end
            end
            ST_TOK2: begin
                if (xfer) begin
                    if (rx_from_eop && crc_ok) begin
                        rx_pid_d   = tok_pid_q;
                        rx_addr_d  = byte1_q[6:0];
                        rx_endp_d  = {rx_from_data[2:0], byte1_q[7]};
                        rx_valid_d = 1'b1;
                        state_d    = ST_OUT;
                    end else if (rx_from_eop) begin
                        rx_err_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        rx_err_d = 1'b1;
                        state_d  = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (xfer && !rx_from_sop && rx_from_eop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (rx_valid_q && rx_ready) begin
                    rx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: ;
        endcase

        // PID byte handling, shared by IDLE and sop-in-DISCARD.
        if (start_pkt) begin
            if ((cls == PID_CLS_INVALID) || !cmp_ok) begin
                rx_err_d = 1'b1;
                state_d  = rx_from_eop ? ST_IDLE : ST_DISCARD;
            end else begin
                con_pid_en_d = 1'b1;
                con_pid_d    = pid_in;
                case (cls)
                    PID_CLS_TOKEN: begin
                        if (rx_from_eop) begin
                            rx_err_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            tok_pid_d = pid_in;
                            state_d   = ST_TOK1;
                        end
                    end
                    PID_CLS_HANDSHAKE: begin
                        if (rx_from_eop) begin
                            state_d = ST_IDLE;
                        end else begin
                            rx_err_d = 1'b1;
                            state_d  = ST_DISCARD;
                        end
                    end
                    default: begin
                        // Data payload is owned by the CRC16 receiver.
                        state_d = rx_from_eop ? ST_IDLE : ST_DISCARD;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tok_pid_q    <= 4'd0;
            byte1_q      <= 8'd0;
            rx_pid_q     <= 4'd0;
            rx_addr_q    <= 7'd0;
            rx_endp_q    <= 4'd0;
            rx_valid_q   <= 1'b0;
            rx_err_q     <= 1'b0;
            con_pid_en_q <= 1'b0;
            con_pid_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            tok_pid_q    <= tok_pid_d;
            byte1_q      <= byte1_d;
            rx_pid_q     <= rx_pid_d;
            rx_addr_q    <= rx_addr_d;
            rx_endp_q    <= rx_endp_d;
            rx_valid_q   <= rx_valid_d;
            rx_err_q     <= rx_err_d;
            con_pid_en_q <= con_pid_en_d;
            con_pid_q    <= con_pid_d;
        end
    end

    assign rx_con_pid_en = con_pid_en_q;
    assign rx_con_pid    = con_pid_q;
    assign rx_pid        = rx_pid_q;
    assign rx_addr       = rx_addr_q;
    assign rx_endp       = rx_endp_q;
    assign rx_valid      = rx_valid_q;
    assign rx_err        = rx_err_q;

endmodule
